// File: rtl/prog_loader.sv
// prog_loader: copies ROM_DEPTH words from a synchronous ROM into the core's instruction memory, holding the core in reset meanwhile.
// Latency: start edge -> FETCH in 3 cycles; 2 cycles per word plus 1 per stalled cycle; done/error the cycle after the last handshake.
// Backpressure: mem_valid held with stable mem_addr/mem_wdata until mem_ready; optional checksum check under PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ROM_DEPTH  = 256,
    parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
    parameter int BASE_ADDR  = 0
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
`ifdef PROG_LOADER_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] checksum_expected,
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  error
);

    localparam int                    IDX_W    = ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(ROM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_go;
    logic             w_start_load;
    logic             w_hs;
    logic             w_last;
    logic             w_fail;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;

    // two-flop synchroniser for the button, plus one register for edge detection
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= start;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // a held button gives exactly one go pulse; go during a copy is dropped
    assign w_go         = r_sync2 & ~r_sync3;
    assign w_start_load = w_go & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
    assign w_hs         = (r_state == S_WRITE) & mem_ready;
    assign w_last       = (r_idx == LAST_IDX);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] w_sum_next;
    logic                  r_error;

    // the final word is folded in before comparing, so the check costs no extra cycle
    assign w_sum_next = r_sum + rom_data;
    assign w_fail     = (w_sum_next != checksum_expected);
    assign checksum   = r_sum;
    assign error      = r_error;

    // running image sum and sticky error flag
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_start_load) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_hs) begin
            r_sum <= w_sum_next;
            if (w_last) begin
                r_error <= w_fail;
            end
        end
    end
`else
    assign w_fail = 1'b0;
    assign error  = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic: FETCH gives the ROM one cycle, WRITE waits for the handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (w_go) w_next = S_FETCH;
            S_FETCH:                 w_next = S_WRITE;
            S_WRITE: begin
                if (w_hs) begin
                    if (!w_last)     w_next = S_FETCH;
                    else if (w_fail) w_next = S_ERROR;
                    else             w_next = S_DONE;
                end
            end
            default:                 w_next = S_IDLE;
        endcase
    end

    // word index and sticky done flag; idx is one bit wider so it never wraps mid-load
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else if (w_start_load) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else if (w_hs) begin
            if (w_last) begin
                r_done <= ~w_fail;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // outputs decoded from state; rom_addr only moves on a handshake, so rom_data stays stable while stalled
    always_comb begin
        busy      = (r_state == S_FETCH) | (r_state == S_WRITE);
        core_hold = busy | (r_state == S_ERROR);
        mem_valid = (r_state == S_WRITE);
        rom_addr  = r_idx[ADDR_WIDTH-1:0];
        mem_addr  = mem_valid ? (BASE + r_idx[ADDR_WIDTH-1:0]) : '0;
        mem_wdata = mem_valid ? rom_data : '0;
        done      = r_done;
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads against a word-list reference model with a decoupled write monitor.
// Covers reset values, start latency, stalls, held/re-pulsed start, mid-load reset and address wrap.
// Checksum scenarios are exercised when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int BASE  = 254;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid;
    logic          mem_ready;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          error;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum_expected;
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] rom [0:(1<<AW)-1];
    wr_t           exp_q[$];
    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            n_wr    = 0;
    int            n_stall = 0;
    int            rdy_mode   = 0;
    int            stall_left = 0;

    prog_loader #(
        .DATA_WIDTH(DW),
        .ROM_DEPTH (DEPTH),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK100MHZ        (clk),
        .reset_n          (reset_n),
        .start            (start),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .core_hold        (core_hold),
        .busy             (busy),
        .done             (done),
`ifdef PROG_LOADER_CHECKSUM_EN
        .checksum_expected(checksum_expected),
        .checksum         (checksum),
`endif
        .error            (error)
    );

    always #5 clk = ~clk;

    // synchronous source ROM: data one cycle after address
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ready driver: always-ready, random, or a 3-cycle stall on word 2
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: mem_ready = ($urandom_range(0, 9) < 6);
                2: begin
                    if (mem_valid && mem_addr == AW'((BASE + 2) % (1 << AW)) && stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // monitor: every presented write must match the head of the expected queue
    initial begin : monitor
        bit prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) chk("valid_held", mem_valid, 1);
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", exp_q.size(), 1);
                end else begin
                    chk("wr_addr", mem_addr, exp_q[0].a);
                    chk("wr_data", mem_wdata, exp_q[0].d);
                    if (mem_ready) begin
                        void'(exp_q.pop_front());
                        n_wr++;
                    end
                end
            end
            prev_stall = mem_valid && !mem_ready;
            if (prev_stall) n_stall++;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_core_hold"}, core_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    // fill ROM and push the expected write list: word i lands at (BASE+i) mod 2^AW
    task automatic load_image(input bit fixed, output logic [DW-1:0] sum);
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_t e;
            rom[i] = fixed ? DW'(i + 1) : DW'($urandom);
            sum    = sum + rom[i];
            e.a    = AW'((BASE + i) % (1 << AW));
            e.d    = rom[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic run_load(input int mode, input bit hold, input bit repulse,
                            input bit fixed, input bit want_err, input string tag);
        logic [DW-1:0] sum;
        int k;
        int cyc;
        int stall0;
        int wr0;
        int exp_cyc;
        load_image(fixed, sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        checksum_expected = want_err ? sum + 1 : sum;
`endif
        rdy_mode   = mode;
        stall_left = 3;
        wr0        = n_wr;
        @(posedge clk);
        #1 start = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (busy || k >= 10) break;
            k++;
        end
        chk({tag, "_go_latency"}, k, 3);
        chk({tag, "_hold_rise"}, core_hold, 1);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_err_clr"}, error, 0);
        stall0 = n_stall;
        if (!hold) begin
            #2 start = 1'b0;
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (repulse && cyc == 3) start = 1'b1;
            if (repulse && cyc == 6) start = hold;
            if (done || error || cyc >= 400) break;
        end
        exp_cyc = 2 * DEPTH + ((mode == 2) ? 3 : (n_stall - stall0));
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_done"}, done, !want_err);
        chk({tag, "_error"}, error, want_err);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_hold_end"}, core_hold, want_err);
        chk({tag, "_nwrites"}, n_wr - wr0, DEPTH);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, sum);
`endif
        if (hold) begin
            repeat (8) @(negedge clk);
            chk({tag, "_no_reload"}, busy, 0);
            chk({tag, "_done_kept"}, done, !want_err);
        end
        start    = 1'b0;
        rdy_mode = 0;
        repeat (5) @(posedge clk);
    endtask

    task automatic reset_mid();
        logic [DW-1:0] sum;
        int k;
        load_image(1'b0, sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        checksum_expected = sum;
`endif
        rdy_mode = 0;
        @(posedge clk);
        #1 start = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if ((mem_valid && mem_addr == AW'((BASE + 2) % (1 << AW))) || k >= 50) break;
            k++;
        end
        chk("rst_reach_word2", mem_valid, 1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        chk_reset_vals("rst_after");
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        reset_n = 1'b0;
        start   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        checksum_expected = '0;
`endif
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        run_load(0, 1'b0, 1'b0, 1'b1, 1'b0, "basic");
        run_load(2, 1'b0, 1'b0, 1'b1, 1'b0, "stall3");
        run_load(0, 1'b1, 1'b1, 1'b1, 1'b0, "held_repulse");
        run_load(0, 1'b0, 1'b0, 1'b1, 1'b0, "reload");
        for (int n = 0; n < 6; n++) begin
            run_load(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, 1'b0, "rand");
        end
        reset_mid();
        run_load(0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
`ifdef PROG_LOADER_CHECKSUM_EN
        run_load(0, 1'b0, 1'b0, 1'b1, 1'b0, "cs_ok");
        run_load(0, 1'b0, 1'b0, 1'b1, 1'b1, "cs_bad");
        run_load(1, 1'b0, 1'b0, 1'b0, 1'b1, "cs_bad_rand");
        run_load(1, 1'b0, 1'b0, 1'b0, 1'b0, "cs_recover");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
